// File: rtl/seq_monitor.sv
// Next-state checker for the 3-bit preset/clear sequence counter.
// Flags illegal steps, counts main-loop passes and latches a fault.
module seq_monitor #(
   parameter int CNT_W     = 8,
   parameter int ERR_LIMIT = 3
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic [2:0]       Q,
   output logic [2:0]       Exp,
   output logic             Mismatch,
   output logic             InLoop,
   output logic             Fault,
   output logic [CNT_W-1:0] LoopCnt,
   output logic [CNT_W-1:0] ErrCnt
);

   typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ERR_LIMIT);

   state_t           state_q, state_d;
   logic [2:0]       prev_q, prev_d;
   logic [2:0]       exp_q, exp_d;
   logic             mism_q, mism_d;
   logic             inloop_q, inloop_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   function automatic logic [2:0] nxt(input logic [2:0] s);
      logic [2:0] r;
      unique case (s)
         3'b000:  r = 3'b110;
         3'b001:  r = 3'b110;
         3'b010:  r = 3'b111;
         3'b011:  r = 3'b000;
         3'b100:  r = 3'b111;
         3'b101:  r = 3'b010;
         3'b110:  r = 3'b100;
         default: r = 3'b011;
      endcase
      return r;
   endfunction

   function automatic logic is_loop(input logic [2:0] s);
      return !(s == 3'b001 || s == 3'b010 || s == 3'b101);
   endfunction

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      exp_d      = exp_q;
      mism_d     = 1'b0;
      inloop_d   = inloop_q;
      fault_d    = fault_q;
      loop_cnt_d = loop_cnt_q;
      err_cnt_d  = err_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (En) begin
               state_d  = TRACK;
               prev_d   = Q;
               exp_d    = nxt(Q);
               inloop_d = is_loop(Q);
            end
         end
         TRACK: begin
            if (En) begin
               if (Q == exp_q) begin
                  if (prev_q == 3'b011 && Q == 3'b000)
                     loop_cnt_d = loop_cnt_q + ONE;
               end else begin
                  mism_d    = 1'b1;
                  err_cnt_d = err_cnt_q + ONE;
                  // Error limit reached: freeze in FAULT on this edge
                  if (err_cnt_d == LIMIT) begin
                     state_d = FAULT;
                     fault_d = 1'b1;
                  end
               end
               prev_d   = Q;
               exp_d    = nxt(Q);
               inloop_d = is_loop(Q);
            end
         end
         FAULT: begin
            fault_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= IDLE;
         prev_q     <= 3'b000;
         exp_q      <= 3'b000;
         mism_q     <= 1'b0;
         inloop_q   <= 1'b0;
         fault_q    <= 1'b0;
         loop_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         exp_q      <= exp_d;
         mism_q     <= mism_d;
         inloop_q   <= inloop_d;
         fault_q    <= fault_d;
         loop_cnt_q <= loop_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign Exp      = exp_q;
   assign Mismatch = mism_q;
   assign InLoop   = inloop_q;
   assign Fault    = fault_q;
   assign LoopCnt  = loop_cnt_q;
   assign ErrCnt   = err_cnt_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Scoreboard bench: two monitors (8-bit and 2-bit counters) on one stream,
// checked each cycle against a table-driven reference model.
module tb_seq_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [2:0] q   = 3'b000;

   logic [2:0] a_exp, b_exp;
   logic       a_mism, a_inl, a_flt;
   logic       b_mism, b_inl, b_flt;
   logic [7:0] a_lc, a_ec;
   logic [1:0] b_lc, b_ec;

   seq_monitor #(.CNT_W(8), .ERR_LIMIT(3)) dut_a (
      .Clk(clk), .Rst(rst), .En(en), .Q(q),
      .Exp(a_exp), .Mismatch(a_mism), .InLoop(a_inl),
      .Fault(a_flt), .LoopCnt(a_lc), .ErrCnt(a_ec)
   );

   seq_monitor #(.CNT_W(2), .ERR_LIMIT(3)) dut_b (
      .Clk(clk), .Rst(rst), .En(en), .Q(q),
      .Exp(b_exp), .Mismatch(b_mism), .InLoop(b_inl),
      .Fault(b_flt), .LoopCnt(b_lc), .ErrCnt(b_ec)
   );

   typedef struct packed {
      logic [2:0] exp;
      logic       mism;
      logic       inl;
      logic       flt;
      logic [7:0] lc;
      logic [7:0] ec;
   } obs_t;

   // Counter successor table, indexed by current state
   logic [2:0] nxt_tbl [8] = '{3'b110, 3'b110, 3'b111, 3'b000,
                               3'b111, 3'b010, 3'b100, 3'b011};

   obs_t       qa[$];
   obs_t       qb[$];
   obs_t       m_o[2];
   bit         m_started[2];
   bit         m_fault[2];
   logic [2:0] m_prev[2];
   bit         mon_on = 1'b0;
   int         checks = 0;
   int         errors = 0;

   function automatic bit in_loop(input logic [2:0] v);
      return v inside {3'b000, 3'b110, 3'b100, 3'b111, 3'b011};
   endfunction

   task automatic model(input int i);
      obs_t o;
      logic [7:0] mask;
      mask = (i == 0) ? 8'hff : 8'h03;
      o = m_o[i];
      o.mism = 1'b0;
      if (rst) begin
         o = '0;
         m_started[i] = 1'b0;
         m_fault[i] = 1'b0;
         m_prev[i] = 3'b000;
      end else if (!m_fault[i] && en) begin
         if (m_started[i] && q != o.exp) begin
            o.mism = 1'b1;
            o.ec = o.ec + 8'd1;
            if (o.ec == 8'd3) begin
               m_fault[i] = 1'b1;
               o.flt = 1'b1;
            end
         end else if (m_started[i] && m_prev[i] == 3'b011 && q == 3'b000) begin
            o.lc = (o.lc + 8'd1) & mask;
         end
         m_started[i] = 1'b1;
         m_prev[i] = q;
         o.exp = nxt_tbl[q];
         o.inl = in_loop(q);
      end
      m_o[i] = o;
   endtask

   task automatic step(input bit r, input bit e, input logic [2:0] v);
      @(negedge clk);
      rst = r;
      en  = e;
      q   = v;
      model(0);
      model(1);
      qa.push_back(m_o[0]);
      qb.push_back(m_o[1]);
      mon_on = 1'b1;
   endtask

   task automatic run(input logic [2:0] vs[$]);
      foreach (vs[k]) step(1'b0, 1'b1, vs[k]);
   endtask

   task automatic loops(input int n);
      step(1'b0, 1'b1, 3'b000);
      repeat (n) run('{3'b110, 3'b100, 3'b111, 3'b011, 3'b000});
   endtask

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, req);
      end
   endtask

   always @(posedge clk) begin
      if (mon_on) begin
         #1;
         if (qa.size() == 0 || qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard empty at %0t", $time);
         end else begin
            obs_t ea, eb;
            ea = qa.pop_front();
            eb = qb.pop_front();
            chk("a_exp",  {5'd0, a_exp}, {5'd0, ea.exp});
            chk("a_mism", {7'd0, a_mism}, {7'd0, ea.mism});
            chk("a_inl",  {7'd0, a_inl}, {7'd0, ea.inl});
            chk("a_flt",  {7'd0, a_flt}, {7'd0, ea.flt});
            chk("a_lc",   a_lc, ea.lc);
            chk("a_ec",   a_ec, ea.ec);
            chk("b_exp",  {5'd0, b_exp}, {5'd0, eb.exp});
            chk("b_mism", {7'd0, b_mism}, {7'd0, eb.mism});
            chk("b_inl",  {7'd0, b_inl}, {7'd0, eb.inl});
            chk("b_flt",  {7'd0, b_flt}, {7'd0, eb.flt});
            chk("b_lc",   {6'd0, b_lc}, eb.lc);
            chk("b_ec",   {6'd0, b_ec}, eb.ec);
         end
      end
   end

   initial begin
      logic [2:0] v;
      bit r, e;
      step(1'b1, 1'b0, 3'b000);
      step(1'b1, 1'b0, 3'b101);
      step(1'b0, 1'b0, 3'b010);
      // plan 1: clean loop
      run('{3'b000, 3'b110, 3'b100, 3'b111, 3'b011, 3'b000});
      // plan 2: transient entry
      step(1'b1, 1'b0, 3'b000);
      run('{3'b101, 3'b010, 3'b111, 3'b011, 3'b000});
      // plan 3: one illegal step then recovery
      step(1'b1, 1'b0, 3'b000);
      run('{3'b000, 3'b110, 3'b010, 3'b111});
      // plan 4: fault after three errors, then frozen
      step(1'b1, 1'b0, 3'b000);
      run('{3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b001, 3'b000});
      step(1'b0, 1'b0, 3'b010);
      // plan 5: strobe gaps with random Q between
      step(1'b1, 1'b0, 3'b000);
      step(1'b0, 1'b1, 3'b110);
      repeat (5) step(1'b0, 1'b0, 3'($urandom));
      step(1'b0, 1'b1, 3'b100);
      // plan 6: wrap on 2-bit counter, reset mid-track
      step(1'b1, 1'b0, 3'b000);
      loops(4);
      step(1'b1, 1'b0, 3'b000);
      loops(2);
      step(1'b1, 1'b1, 3'b110);
      step(1'b0, 1'b1, 3'b011);
      step(1'b0, 1'b1, 3'b000);
      // randomized traffic biased toward legal steps
      repeat (800) begin
         r = ($urandom_range(0, 59) == 0);
         e = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 8)
            v = m_o[0].exp;
         else
            v = 3'($urandom);
         step(r, e, v);
      end
      @(posedge clk);
      #2;
      mon_on = 1'b0;
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard residue: got %0d want 0",
                  qa.size() + qb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_monitor.md
Name: seq_monitor

Overview:
- Downstream checker for the 3-bit preset/clear sequence counter. Samples the counter's Q output and checks each advance against the fixed next-state table.
- Reports illegal steps, counts completed passes through the main loop, flags whether the counter is in a transient or loop state, and latches a fault after repeated errors.
- Sits beside the counter in the CE213 lab top-level; En is driven high on cycles where the counter advanced (Prs and Clr both zero).

Parameters:
- CNT_W, 8, width of LoopCnt and ErrCnt.
- ERR_LIMIT, 3, mismatch count that forces the FAULT state (1..2^CNT_W-1).

Ports:
- Clk  input  1  rising-edge clock, shared with the counter.
- Rst  input  1  synchronous, active-high reset.
- En  input  1  sample strobe: Q is a new counter state this cycle.
- Q  input  3  counter state being monitored.
- Exp  output  3  expected value of the next sample.
- Mismatch  output  1  one-cycle pulse, registered, on an illegal step.
- InLoop  output  1  last sample is a loop state.
- Fault  output  1  sticky fault flag.
- LoopCnt  output  CNT_W  completed loops through 000 (wraps).
- ErrCnt  output  CNT_W  mismatches seen (saturates at ERR_LIMIT).

Behaviour:
- One clock domain; all outputs are registered. Rst is sampled at posedge Clk and dominates all other inputs.
- Reset values: every output is 0, Exp=000, state=IDLE, internal prev=000.
- Next-state table nxt():
  - 000->110, 001->110, 010->111, 011->000
  - 100->111, 101->010, 110->100, 111->011
- Loop states: {000,110,100,111,011}, a 5-cycle loop. Transient states: {001,010,101}.
- FSM states: IDLE, TRACK, FAULT.
- IDLE:
  - En=0: hold.
  - En=1: prev<=Q, Exp<=nxt(Q), InLoop<=loop(Q), go to TRACK. No check is made on the first sample.
- TRACK, En=0: everything holds. Q may take any value between strobes without an error.
- TRACK, En=1 and Q==Exp:
  - prev<=Q, Exp<=nxt(Q), InLoop<=loop(Q).
  - If prev==011 and Q==000, then LoopCnt<=LoopCnt+1, modulo 2^CNT_W.
- TRACK, En=1 and Q!=Exp:
  - Mismatch=1 for exactly the following cycle.
  - ErrCnt<=ErrCnt+1; resync with prev<=Q, Exp<=nxt(Q), InLoop<=loop(Q).
  - No LoopCnt increment, even when Q==000.
  - If the new ErrCnt==ERR_LIMIT, go to FAULT on the same edge, with Mismatch still pulsed and Fault=1.
- FAULT:
  - Fault=1.
  - En is ignored; Exp, InLoop, LoopCnt and ErrCnt are frozen.
  - Mismatch returns to 0.
  - Only Rst exits FAULT.
- Latency: a sample on edge N produces updated Exp, InLoop, LoopCnt, ErrCnt and Mismatch visible after edge N, i.e. one cycle later.
- ErrCnt never exceeds ERR_LIMIT.
- Rst mid-operation clears all state. The next En sample is treated as a first sample, as in IDLE.
- Q containing X/Z is out of scope; the bench drives only defined values.

Test Plan:
1. Rst, then En=1 every cycle with Q=000,110,100,111,011,000 -> Mismatch stays 0, LoopCnt=1 after the 6th sample, InLoop=1 throughout, Exp=110 at the end.
2. Transient entry: Q=101,010,111,011,000 with En=1 -> InLoop=0,0,1,1,1, no Mismatch, LoopCnt=1.
3. Illegal step: Q=000,110,010 -> Mismatch=1 for one cycle after the 010 sample, ErrCnt=1, Exp=111. Then Q=111 is accepted cleanly.
4. Fault, ERR_LIMIT=3: three illegal steps (e.g. 000,000,000,000) -> ErrCnt=3 and Fault=1 after the 4th sample. Further En pulses with bad Q leave ErrCnt=3 and Mismatch=0.
5. Strobe gaps: samples 110 and 100 separated by 5 cycles of En=0 while Q toggles randomly -> no Mismatch, Exp=111.
6. Reset handling:
   - CNT_W=2: run 4 full loops -> LoopCnt wraps to 0.
   - Assert Rst mid-TRACK with LoopCnt=2 -> all outputs 0 next cycle. The next sample (Q=011) raises no Mismatch and gives Exp=000.
